// File: rtl/nios2_dmem_pkg.sv
// Shared types and address decode for the Nios II tightly coupled data memory.
package nios2_dmem_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    typedef struct packed {
        logic outOfRange;
        logic misaligned;
    } addr_flags_t;

    // A byte address is legal when it falls inside the array and is word aligned.
    function automatic addr_flags_t decodeAddr(input logic [31:0] addr, input int unsigned depth);
        addr_flags_t f;
        f.outOfRange = (addr >= (depth << 2));
        f.misaligned = (addr[1:0] != 2'b00);
        return f;
    endfunction

endpackage

// File: rtl/nios2_dmem_ram.sv
// Single-port word array with a read-before-write registered read port.
// DMEM_PARITY_EN adds one even-parity bit per word and a read-side parity check.
module nios2_dmem_ram
    import nios2_dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_i,
    input  logic                     wr_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     par_err_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wr_i) mem[addr_i] <= wdata_i;
    end

    // Separate process from the write so a same-cycle read sees the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (rd_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef DMEM_PARITY_EN
    logic par [DEPTH];
    logic parRd_q;
    logic rdValid_q;

    always_ff @(posedge clk) begin
        if (wr_i) par[addr_i] <= ^wdata_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parRd_q   <= 1'b0;
            rdValid_q <= 1'b0;
        end else begin
            rdValid_q <= rd_i;
            if (rd_i) parRd_q <= par[addr_i];
        end
    end

    assign par_err_o = rdValid_q && ((^rdata_q) ^ parRd_q);
`else
    assign par_err_o = 1'b0;
`endif

endmodule

// File: rtl/nios2_dmem.sv
// Nios II data memory: clear sequencer, run/halt control, core/host arbitration, error flags.
// Optional parity protection is enabled with DMEM_PARITY_EN.
module nios2_dmem
    import nios2_dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    input  logic        host_valid_i,
    output logic        host_ready_o,
    input  logic        host_wr_i,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic [31:0] host_rdata_o,
    output logic        host_rvalid_o,
    input  logic        host_start_i,
    input  logic        host_halt_i,
    output logic        core_enable_o,
    output logic        init_done_o,
    output logic        addr_err_o,
    output logic        par_err_o
);

    localparam int AW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] clrCnt_q;
    logic          initDone_q, coreEn_q, coreRdPend_q, hostRdPend_q, rdOor_q, addrErr_q;
    logic [DW-1:0] memHold_q, hostHold_q;

    logic          coreReq, hostAcc, reqRd, reqWr, ramRd, ramWr, ramParErr;
    logic [31:0]   selAddr;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramWdata, ramRdata;
    addr_flags_t   addrFlags;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (clrCnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
            ST_IDLE: if (host_start_i && !host_halt_i) state_d = ST_RUN;
            ST_RUN:  if (host_halt_i) state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // The core owns the array whenever it strobes in RUN; the host gets the leftover cycles.
    always_comb begin
        coreReq      = (state_q == ST_RUN) && (mem_rd_i || mem_wr_i);
        host_ready_o = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !(mem_rd_i || mem_wr_i));
        hostAcc      = host_valid_i && host_ready_o;
        selAddr      = coreReq ? mem_addr_i : host_addr_i;
        addrFlags    = decodeAddr(selAddr, DEPTH);
        reqRd        = coreReq ? mem_rd_i : (hostAcc && !host_wr_i);
        reqWr        = coreReq ? mem_wr_i : (hostAcc && host_wr_i);
        ramRd        = reqRd && !addrFlags.outOfRange;
        ramWr        = reqWr && !addrFlags.outOfRange;
        ramAddr      = selAddr[AW+1:2];
        ramWdata     = coreReq ? mem_wdata_i : host_wdata_i;
        if (state_q == ST_INIT) begin
            ramRd    = 1'b0;
            ramWr    = 1'b1;
            ramAddr  = clrCnt_q;
            ramWdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            clrCnt_q     <= '0;
            initDone_q   <= 1'b0;
            coreEn_q     <= 1'b0;
            coreRdPend_q <= 1'b0;
            hostRdPend_q <= 1'b0;
            rdOor_q      <= 1'b0;
            addrErr_q    <= 1'b0;
            memHold_q    <= '0;
            hostHold_q   <= '0;
        end else begin
            state_q      <= state_d;
            coreEn_q     <= (state_d == ST_RUN);
            if (state_q == ST_INIT) clrCnt_q <= clrCnt_q + AW'(1);
            if ((state_q == ST_INIT) && (state_d == ST_IDLE)) initDone_q <= 1'b1;
            coreRdPend_q <= coreReq && mem_rd_i;
            hostRdPend_q <= hostAcc && !host_wr_i;
            rdOor_q      <= addrFlags.outOfRange;
            addrErr_q    <= (coreReq || hostAcc) && (addrFlags.outOfRange || addrFlags.misaligned);
            memHold_q    <= mem_rdata_o;
            hostHold_q   <= host_rdata_o;
        end
    end

    nios2_dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk       (clk),
        .rst       (rst),
        .rd_i      (ramRd),
        .wr_i      (ramWr),
        .addr_i    (ramAddr),
        .wdata_i   (ramWdata),
        .rdata_o   (ramRdata),
        .par_err_o (ramParErr)
    );

    // Load data is live only in the cycle after a read; otherwise the last result is held.
    assign mem_rdata_o   = coreRdPend_q ? (rdOor_q ? '0 : ramRdata) : memHold_q;
    assign host_rdata_o  = hostRdPend_q ? (rdOor_q ? '0 : ramRdata) : hostHold_q;
    assign host_rvalid_o = hostRdPend_q;
    assign core_enable_o = coreEn_q;
    assign init_done_o   = initDone_q;
    assign addr_err_o    = addrErr_q;
    assign par_err_o     = ramParErr;

endmodule

// File: tb/tb_nios2_dmem.sv
// Randomized self-checking bench for nios2_dmem against a word-array reference model.
// Define DMEM_PARITY_EN to also exercise the parity-error path.
module tb_nios2_dmem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_rd_i = 1'b0, mem_wr_i = 1'b0;
    logic [31:0] mem_addr_i = '0, mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        host_valid_i = 1'b0, host_wr_i = 1'b0;
    logic [31:0] host_addr_i = '0, host_wdata_i = '0;
    logic        host_ready_o;
    logic [31:0] host_rdata_o;
    logic        host_rvalid_o;
    logic        host_start_i = 1'b0, host_halt_i = 1'b0;
    logic        core_enable_o, init_done_o, addr_err_o, par_err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [256];
    logic [31:0] expLoad;

    always #5 clk = ~clk;

    nios2_dmem dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd_i      (mem_rd_i),
        .mem_wr_i      (mem_wr_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_rdata_o   (mem_rdata_o),
        .host_valid_i  (host_valid_i),
        .host_ready_o  (host_ready_o),
        .host_wr_i     (host_wr_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_rdata_o  (host_rdata_o),
        .host_rvalid_o (host_rvalid_o),
        .host_start_i  (host_start_i),
        .host_halt_i   (host_halt_i),
        .core_enable_o (core_enable_o),
        .init_done_o   (init_done_o),
        .addr_err_o    (addr_err_o),
        .par_err_o     (par_err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        expLoad = 32'h0;
    endtask

    task automatic waitInit(output int n, output logic sawReady);
        n = 0;
        sawReady = 1'b0;
        host_valid_i = 1'b1;
        host_wr_i = 1'b0;
        while (n < 1000) begin
            if (host_ready_o !== 1'b0) sawReady = 1'b1;
            step();
            n++;
            if (init_done_o === 1'b1) break;
        end
        host_valid_i = 1'b0;
    endtask

    task automatic hostWrite(input logic [31:0] a, input logic [31:0] d);
        host_valid_i = 1'b1; host_wr_i = 1'b1; host_addr_i = a; host_wdata_i = d;
        step();
        host_valid_i = 1'b0; host_wr_i = 1'b0;
        if (a < 32'h400) model[a[9:2]] = d;
    endtask

    task automatic hostRead(input logic [31:0] a);
        host_valid_i = 1'b1; host_wr_i = 1'b0; host_addr_i = a;
        step();
        host_valid_i = 1'b0;
    endtask

    task automatic coreOp(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        mem_rd_i = rd; mem_wr_i = wr; mem_addr_i = a; mem_wdata_i = d;
        step();
        mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic sawReady;
        clearModel();
        #2;
        checks++;
        if ({mem_rdata_o, host_rdata_o, host_ready_o, host_rvalid_o, core_enable_o, init_done_o, addr_err_o, par_err_o} !== 70'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdata %h hrdata %h flags %b, required all zero", mem_rdata_o, host_rdata_o,
                     {host_ready_o, host_rvalid_o, core_enable_o, init_done_o, addr_err_o, par_err_o});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        waitInit(n, sawReady);
        checks++;
        if (n !== 256) begin errors++; $display("[TB] FAIL init_cycles: got %0d required 256", n); end
        checks++;
        if (sawReady !== 1'b0) begin errors++; $display("[TB] FAIL init_ready: host_ready_o seen %b required 0", sawReady); end
        checks++;
        if (core_enable_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_enable: got %b required 0", core_enable_o); end
        hostRead(32'h3FC);
        checks++;
        if (host_rvalid_o !== 1'b1 || host_rdata_o !== 32'h0) begin
            errors++; $display("[TB] FAIL read_last_word: rvalid %b data %h required 1 00000000", host_rvalid_o, host_rdata_o);
        end
    endtask

    task automatic test_host_rw();
        logic [31:0] addrs [8];
        hostWrite(32'h10, 32'hDEADBEEF);
        hostRead(32'h10);
        checks++;
        if (host_rvalid_o !== 1'b1 || host_rdata_o !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL host_read_10: rvalid %b data %h required 1 deadbeef", host_rvalid_o, host_rdata_o);
        end
        step();
        checks++;
        if (host_rvalid_o !== 1'b0 || host_rdata_o !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL host_hold: rvalid %b data %h required 0 deadbeef", host_rvalid_o, host_rdata_o);
        end
        for (int i = 0; i < 8; i++) begin
            addrs[i] = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            hostWrite(addrs[i], $urandom);
        end
        for (int i = 0; i < 8; i++) begin
            hostRead(addrs[i]);
            checks++;
            if (host_rdata_o !== model[addrs[i][9:2]] || par_err_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL host_rand_read @%h: data %h par %b required %h 0", addrs[i], host_rdata_o, par_err_o, model[addrs[i][9:2]]);
            end
        end
        hostRead(32'h800);
        checks++;
        if (host_rvalid_o !== 1'b1 || host_rdata_o !== 32'h0 || addr_err_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL host_oor_read: rvalid %b data %h aerr %b required 1 00000000 1", host_rvalid_o, host_rdata_o, addr_err_o);
        end
    endtask

    task automatic test_run_core();
        logic rd, wr;
        int idx;
        logic [31:0] d, exp;
        logic sawAerr;
        host_start_i = 1'b1;
        step();
        host_start_i = 1'b0;
        checks++;
        if (core_enable_o !== 1'b1) begin errors++; $display("[TB] FAIL start_enable: got %b required 1", core_enable_o); end
        coreOp(1'b0, 1'b1, 32'h20, 32'h12345678);
        model[8] = 32'h12345678;
        coreOp(1'b1, 1'b0, 32'h20, 32'h0);
        expLoad = 32'h12345678;
        checks++;
        if (mem_rdata_o !== 32'h12345678) begin errors++; $display("[TB] FAIL core_load_20: got %h required 12345678", mem_rdata_o); end
        coreOp(1'b1, 1'b1, 32'h20, 32'hA5A5_0001);
        checks++;
        if (mem_rdata_o !== 32'h12345678) begin errors++; $display("[TB] FAIL core_rdwr_old: got %h required 12345678", mem_rdata_o); end
        model[8] = 32'hA5A5_0001;
        sawAerr = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 255);
            d = $urandom;
            exp = rd ? model[idx] : expLoad;
            coreOp(rd, wr, 32'(idx) << 2, d);
            if (addr_err_o !== 1'b0) sawAerr = 1'b1;
            checks++;
            if (mem_rdata_o !== exp) begin
                errors++; $display("[TB] FAIL core_rand[%0d] rd %b wr %b idx %0d: got %h required %h", i, rd, wr, idx, mem_rdata_o, exp);
            end
            if (wr) model[idx] = d;
            expLoad = exp;
        end
        checks++;
        if (sawAerr !== 1'b0) begin errors++; $display("[TB] FAIL core_rand_aerr: got %b required 0", sawAerr); end
    endtask

    task automatic test_contention();
        mem_rd_i = 1'b1; mem_addr_i = 32'h20;
        host_valid_i = 1'b1; host_wr_i = 1'b0; host_addr_i = 32'h10;
        #1;
        checks++;
        if (host_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL contention_ready: got %b required 0", host_ready_o); end
        step();
        mem_rd_i = 1'b0;
        expLoad = model[8];
        checks++;
        if (mem_rdata_o !== model[8] || host_rvalid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL contention_core: data %h rvalid %b required %h 0", mem_rdata_o, host_rvalid_o, model[8]);
        end
        #1;
        checks++;
        if (host_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL contention_release: got %b required 1", host_ready_o); end
        step();
        host_valid_i = 1'b0;
        checks++;
        if (host_rvalid_o !== 1'b1 || host_rdata_o !== model[4]) begin
            errors++; $display("[TB] FAIL contention_host: rvalid %b data %h required 1 %h", host_rvalid_o, host_rdata_o, model[4]);
        end
    endtask

    task automatic test_addr_err();
        coreOp(1'b1, 1'b0, 32'h400, 32'h0);
        checks++;
        if (addr_err_o !== 1'b1 || mem_rdata_o !== 32'h0) begin
            errors++; $display("[TB] FAIL load_400: aerr %b data %h required 1 00000000", addr_err_o, mem_rdata_o);
        end
        coreOp(1'b1, 1'b0, 32'h22, 32'h0);
        checks++;
        if (addr_err_o !== 1'b1 || mem_rdata_o !== model[8]) begin
            errors++; $display("[TB] FAIL load_22: aerr %b data %h required 1 %h", addr_err_o, mem_rdata_o, model[8]);
        end
        coreOp(1'b0, 1'b1, 32'h404, 32'hFFFF_FFFF);
        checks++;
        if (addr_err_o !== 1'b1) begin errors++; $display("[TB] FAIL store_404_aerr: got %b required 1", addr_err_o); end
        coreOp(1'b1, 1'b0, 32'h04, 32'h0);
        expLoad = model[1];
        checks++;
        if (addr_err_o !== 1'b0 || mem_rdata_o !== model[1]) begin
            errors++; $display("[TB] FAIL oor_store_dropped: aerr %b data %h required 0 %h", addr_err_o, mem_rdata_o, model[1]);
        end
    endtask

    task automatic test_halt();
        int idx;
        host_start_i = 1'b1; host_halt_i = 1'b1;
        step();
        host_start_i = 1'b0; host_halt_i = 1'b0;
        checks++;
        if (core_enable_o !== 1'b0) begin errors++; $display("[TB] FAIL halt_wins: got %b required 0", core_enable_o); end
        mem_wr_i = 1'b1; mem_rd_i = 1'b1; mem_addr_i = 32'h30; mem_wdata_i = 32'hCAFEF00D;
        #1;
        checks++;
        if (host_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b required 1", host_ready_o); end
        step();
        mem_wr_i = 1'b0; mem_rd_i = 1'b0;
        checks++;
        if (mem_rdata_o !== expLoad) begin errors++; $display("[TB] FAIL idle_load_ignored: got %h required %h", mem_rdata_o, expLoad); end
        hostRead(32'h30);
        checks++;
        if (host_rdata_o !== model[12]) begin errors++; $display("[TB] FAIL idle_store_ignored: got %h required %h", host_rdata_o, model[12]); end
        for (int i = 0; i < 6; i++) begin
            idx = $urandom_range(0, 255);
            hostRead(32'(idx) << 2);
            checks++;
            if (host_rdata_o !== model[idx]) begin
                errors++; $display("[TB] FAIL post_run_read idx %0d: got %h required %h", idx, host_rdata_o, model[idx]);
            end
        end
    endtask

    task automatic test_parity();
`ifdef DMEM_PARITY_EN
        hostWrite(32'h10, 32'h0F0F_1234);
        dut.u_ram.mem[4] = dut.u_ram.mem[4] ^ 32'h0000_0100;
        model[4] = 32'h0F0F_1334;
        hostRead(32'h10);
        checks++;
        if (par_err_o !== 1'b1 || host_rdata_o !== model[4]) begin
            errors++; $display("[TB] FAIL parity_flip: par %b data %h required 1 %h", par_err_o, host_rdata_o, model[4]);
        end
        hostWrite(32'h10, 32'h0F0F_1234);
        hostRead(32'h10);
        checks++;
        if (par_err_o !== 1'b0 || host_rdata_o !== 32'h0F0F_1234) begin
            errors++; $display("[TB] FAIL parity_rewrite: par %b data %h required 0 0f0f1234", par_err_o, host_rdata_o);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        int n;
        logic sawReady;
        host_start_i = 1'b1;
        step();
        host_start_i = 1'b0;
        coreOp(1'b1, 1'b0, 32'h20, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (core_enable_o !== 1'b0 || init_done_o !== 1'b0 || host_ready_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset: en %b done %b ready %b data %h required 0 0 0 00000000", core_enable_o, init_done_o, host_ready_o, mem_rdata_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        clearModel();
        waitInit(n, sawReady);
        checks++;
        if (n !== 256) begin errors++; $display("[TB] FAIL reinit_cycles: got %0d required 256", n); end
        hostRead(32'h20);
        checks++;
        if (host_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL reinit_cleared: got %h required 00000000", host_rdata_o); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_host_rw();
        test_run_core();
        test_contention();
        test_addr_err();
        test_halt();
        test_parity();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
